// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: size codes, FSM states,
// store byte-enable generation, misalignment test and load data alignment.
package dmem_pkg;

  localparam int unsigned DMEM_XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = 4'b0011 << off;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [DMEM_XLEN-1:0] load_align(input logic [31:0] word,
                                                     input logic [1:0]  size,
                                                     input logic [1:0]  off);
    logic [31:0] sh;
    logic [DMEM_XLEN-1:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  res = {24'h0, sh[7:0]};
      SIZE_H:  res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response channel between the load/store stage (master) and dmem_resp (slave).
// Signal suffixes follow the responder's point of view.
interface dmem_resp_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [1:0]      req_size_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, byte write enables and registered
// read data; the array itself has no reset.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding load/store, LATENCY wait states, then a held response.
// Optional DMEM_RANGE_CHECK_EN flags addresses beyond the RAM instead of aliasing them.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic        clk,
  input logic        reset,
  dmem_resp_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_load_q, rsp_load_d;

  logic            in_idle, accept, enter_resp;
  logic            cur_we, cur_err, range_err;
  logic [1:0]      cur_size;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [3:0]      ram_be;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_wdata, ram_rdata;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle & bus.req_valid_i;

  // With LATENCY=0 the RAM is touched on the accepting edge, so take the live request.
  assign cur_we    = in_idle ? bus.req_we_i    : we_q;
  assign cur_size  = in_idle ? bus.req_size_i  : size_q;
  assign cur_addr  = in_idle ? bus.req_addr_i  : addr_q;
  assign cur_wdata = in_idle ? bus.req_wdata_i : wdata_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err = |cur_addr[XLEN-1:AW+2];
`else
  logic unused_addr_hi;
  assign range_err      = 1'b0;
  assign unused_addr_hi = ^cur_addr[XLEN-1:AW+2];
`endif

  assign cur_err   = misaligned(cur_size, cur_addr[1:0]) | range_err;
  assign ram_addr  = cur_addr[AW+1:2];
  assign ram_wdata = 32'(cur_wdata << {cur_addr[1:0], 3'b000});
  assign ram_be    = (enter_resp & cur_we & ~cur_err) ? byte_en(cur_size, cur_addr[1:0]) : 4'b0000;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    enter_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q & bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_load_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err;
      rsp_load_d  = ~cur_we & ~cur_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we_i;
      size_q  <= bus.req_size_i;
      addr_q  <= bus.req_addr_i;
      wdata_q <= bus.req_wdata_i;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .en_i   (enter_resp),
    .be_i   (ram_be),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // RAM output register is only refreshed on RESP entry, so it holds for the whole response.
  assign bus.req_ready_o = in_idle;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_load_q ? XLEN'(load_align(ram_rdata, size_q, addr_q[1:0])) : '0;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed vector table, hand-written hold/reset sequences and
// random traffic against a byte-array memory model.
module tb_dmem_resp;

  localparam int unsigned LAT = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_resp_if #(.XLEN(32)) bus ();

  dmem_resp #(
    .XLEN       (32),
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [7:0] mem_m [0:4095];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural memory: little-endian bytes, 4 KiB window, aligned accesses only.
  function automatic void model(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int nb;
    int base;
    er = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHECK_EN
    er = er || (ad >= 32'h1000);
`endif
    rd = 32'h0;
    if (er) return;
    nb   = 1 << sz;
    base = int'(ad % 32'd4096);
    for (int i = 0; i < nb; i++) begin
      if (we) mem_m[base + i] = wd[8*i +: 8];
      else    rd = rd | (32'(mem_m[base + i]) << (8 * i));
    end
  endfunction

  // One transaction; hold>0 stalls rsp_ready and pushes an intruding store meanwhile.
  task automatic xact(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    int lat;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("req_ready_timeout", 32'(n), 32'd0);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_size_i  = sz;
    bus.req_addr_i  = ad;
    bus.req_wdata_i = wd;
    bus.rsp_ready_i = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("ready_low_after_accept", 32'(bus.req_ready_o), 32'd0);
    lat = 1;
    while (!bus.rsp_valid_o && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("handshake_edge", 32'(lat), 32'(LAT + 1));
    rd = bus.rsp_rdata_o;
    er = bus.rsp_err_o;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_size_i  = 2'b10;
      bus.req_addr_i  = ad & 32'hFFFF_FFFC;
      bus.req_wdata_i = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("hold_rdata", bus.rsp_rdata_o, rd);
      chk("hold_err", 32'(bus.rsp_err_o), 32'(er));
      chk("hold_req_ready", 32'(bus.req_ready_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("post_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("post_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_er);
    vec_t v;
    v.nm = nm; v.we = we; v.sz = sz; v.ad = ad; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_er = exp_er;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] ad, wd;

    checks = 0;
    errors = 0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_size_i  = 2'b00;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.rsp_ready_i = 1'b1;
    reset = 1'b1;
    #1;
    chk("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("reset_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Preload low 256 bytes so every later load has defined contents.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      xact(1'b1, 2'b10, 32'(w * 4), wd, 0, rd, er);
      model(1'b1, 2'b10, 32'(w * 4), wd, mrd, mer);
    end

    vecs.push_back(mk("st_w_10",    1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk("ld_w_10",    0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("st_w_10b",   1, 2'b10, 32'h10, 32'h11223344, 32'h0, 0));
    vecs.push_back(mk("st_b_13",    1, 2'b00, 32'h13, 32'h000000AA, 32'h0, 0));
    vecs.push_back(mk("ld_w_10b",   0, 2'b10, 32'h10, 32'h0, 32'hAA223344, 0));
    vecs.push_back(mk("ld_h_12",    0, 2'b01, 32'h12, 32'h0, 32'h0000AA22, 0));
    vecs.push_back(mk("ld_b_13",    0, 2'b00, 32'h13, 32'h0, 32'h000000AA, 0));
    vecs.push_back(mk("st_w_00",    1, 2'b10, 32'h00, 32'h01020304, 32'h0, 0));
    vecs.push_back(mk("st_w_04",    1, 2'b10, 32'h04, 32'h05060708, 32'h0, 0));
    vecs.push_back(mk("ld_w_06",    0, 2'b10, 32'h06, 32'h0, 32'h0, 1));
    vecs.push_back(mk("st_h_01",    1, 2'b01, 32'h01, 32'h0000BEEF, 32'h0, 1));
    vecs.push_back(mk("st_x_04",    1, 2'b11, 32'h04, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk("ld_x_00",    0, 2'b11, 32'h00, 32'h0, 32'h0, 1));
    vecs.push_back(mk("ld_w_00",    0, 2'b10, 32'h00, 32'h0, 32'h01020304, 0));
    vecs.push_back(mk("ld_w_04",    0, 2'b10, 32'h04, 32'h0, 32'h05060708, 0));
`ifdef DMEM_RANGE_CHECK_EN
    vecs.push_back(mk("ld_w_1000",  0, 2'b10, 32'h1000, 32'h0, 32'h0, 1));
    vecs.push_back(mk("st_w_1004",  1, 2'b10, 32'h1004, 32'hCAFEF00D, 32'h0, 1));
    vecs.push_back(mk("ld_w_04_al", 0, 2'b10, 32'h04, 32'h0, 32'h05060708, 0));
`else
    vecs.push_back(mk("ld_w_1000",  0, 2'b10, 32'h1000, 32'h0, 32'h01020304, 0));
    vecs.push_back(mk("st_w_1004",  1, 2'b10, 32'h1004, 32'hCAFEF00D, 32'h0, 0));
    vecs.push_back(mk("ld_w_04_al", 0, 2'b10, 32'h04, 32'h0, 32'hCAFEF00D, 0));
`endif
    vecs.push_back(mk("st_h_02",    1, 2'b01, 32'h02, 32'hFFFF1234, 32'h0, 0));
    vecs.push_back(mk("ld_w_00b",   0, 2'b10, 32'h00, 32'h0, 32'h12340304, 0));
    vecs.push_back(mk("ld_b_01",    0, 2'b00, 32'h01, 32'h0, 32'h00000003, 0));
    vecs.push_back(mk("ld_h_00",    0, 2'b01, 32'h00, 32'h0, 32'h00000304, 0));

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].sz, vecs[i].ad, vecs[i].wd, 0, rd, er);
      model(vecs[i].we, vecs[i].sz, vecs[i].ad, vecs[i].wd, mrd, mer);
      chk({vecs[i].nm, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].nm, "_err"}, 32'(er), 32'(vecs[i].exp_er));
    end

    // Stalled response with a competing request on the bus.
    xact(1'b0, 2'b10, 32'h10, 32'h0, 5, rd, er);
    chk("hold_ld_rdata", rd, 32'hAA223344);
    chk("hold_ld_err", 32'(er), 32'd0);
    xact(1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er);
    chk("after_hold_rdata", rd, 32'hAA223344);

    // Reset while a store sits in WAIT: it must never reach the RAM.
    xact(1'b1, 2'b10, 32'h20, 32'h11111111, 0, rd, er);
    model(1'b1, 2'b10, 32'h20, 32'h11111111, mrd, mer);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_size_i  = 2'b00;
    bus.req_addr_i  = 32'h20;
    bus.req_wdata_i = 32'h00000055;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("mid_accepted", 32'(bus.req_ready_o), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("mid_reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("mid_reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("mid_reset_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 2'b10, 32'h20, 32'h0, 0, rd, er);
    chk("after_reset_ld_20", rd, 32'h11111111);

    // Random traffic against the model.
    for (int t = 0; t < 250; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 255));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) ad = ad | 32'h1000;
      xact(we, sz, ad, wd, (t % 17 == 0) ? 2 : 0, rd, er);
      model(we, sz, ad, wd, mrd, mer);
      chk("rand_rdata", rd, mrd);
      chk("rand_err", 32'(er), 32'(mer));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
